// File: rtl/line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// line_mem_arbiter
//
// Shares one line-wide RAM port between the instruction-cache miss path
// (port I) and the data-cache writeback/allocate path (port D). Only one line
// transaction is in flight at a time: either a LINE_WIDTH refill read or a
// LINE_WIDTH writeback. Requests are arbitrated round-robin. The winning
// transaction is issued to RAM, and the response is routed back to the port
// that owns it. A response watchdog converts a hung RAM into an error
// response, so that neither cache can deadlock.
//
// Parameters
//   ADDR_WIDTH    byte address width on all ports
//   LINE_WIDTH    cache line width in bits
//   RESP_TIMEOUT  cycles waited for a RAM response before an error response
//                 (0 disables the watchdog)
//   CNT_WIDTH     watchdog counter width, 2**CNT_WIDTH > RESP_TIMEOUT
//
// Ports
//   clk, RESET                  clock (rising edge), async active-low reset
//   i_req_* / d_req_*           request: valid, rw (0=read 1=write), addr,
//                               wdata; *_req_ready is the combinational accept
//   i_resp_* / d_resp_*         one-cycle response pulse, read line, and
//                               watchdog error flag
//   mem_valid/rw/addr/wdata     registered RAM request; addr is line-aligned
//   mem_ready                   RAM accepts when mem_valid & mem_ready
//   mem_resp_valid, mem_rdata   RAM read data valid or write done
//   busy                        high whenever the arbiter is not IDLE
// -----------------------------------------------------------------------------
module line_mem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 128,
  parameter int RESP_TIMEOUT = 1023,
  parameter int CNT_WIDTH    = 10
) (
  input  logic                  clk,
  input  logic                  RESET,
  // port I
  input  logic                  i_req_valid,
  input  logic                  i_req_rw,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  input  logic [LINE_WIDTH-1:0] i_req_wdata,
  output logic                  i_req_ready,
  output logic                  i_resp_valid,
  output logic [LINE_WIDTH-1:0] i_resp_rdata,
  output logic                  i_resp_err,
  // port D
  input  logic                  d_req_valid,
  input  logic                  d_req_rw,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [LINE_WIDTH-1:0] d_req_wdata,
  output logic                  d_req_ready,
  output logic                  d_resp_valid,
  output logic [LINE_WIDTH-1:0] d_resp_rdata,
  output logic                  d_resp_err,
  // RAM port
  output logic                  mem_valid,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic                  mem_resp_valid,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  // status
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  // The watchdog fires on the last counted cycle. With RESP_TIMEOUT == 0, the
  // cast wraps to all-ones, but WDOG_EN masks the comparison off entirely.
  localparam bit                   WDOG_EN   = (RESP_TIMEOUT != 0);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(RESP_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK = {{(ADDR_WIDTH-4){1'b1}}, 4'b0000};

  state_t                  state_r;
  state_t                  state_s;
  port_t                   owner_r;
  port_t                   rr_last_r;
  logic                    rw_r;
  logic [ADDR_WIDTH-1:0]   addr_r;
  logic [LINE_WIDTH-1:0]   wdata_r;
  logic                    mem_valid_r;
  logic [CNT_WIDTH-1:0]    cnt_r;
  logic                    busy_r;
  logic                    i_resp_valid_r;
  logic                    i_resp_err_r;
  logic [LINE_WIDTH-1:0]   i_resp_rdata_r;
  logic                    d_resp_valid_r;
  logic                    d_resp_err_r;
  logic [LINE_WIDTH-1:0]   d_resp_rdata_r;

  logic                    grant_i_s;
  logic                    grant_d_s;
  logic                    accept_s;
  logic                    issue_done_s;
  logic                    resp_hit_s;
  logic                    timeout_s;
  logic                    sel_rw_s;
  logic [ADDR_WIDTH-1:0]   sel_addr_s;
  logic [LINE_WIDTH-1:0]   sel_wdata_s;
  logic [LINE_WIDTH-1:0]   resp_data_s;

  // Round-robin grant in IDLE: a lone requester wins, and on a tie the port
  // that did not win last time wins.
  always_comb begin
    grant_i_s = 1'b0;
    grant_d_s = 1'b0;
    if (state_r == IDLE) begin
      if (i_req_valid && d_req_valid) begin
        if (rr_last_r == PORT_I) begin
          grant_d_s = 1'b1;
        end else begin
          grant_i_s = 1'b1;
        end
      end else if (i_req_valid) begin
        grant_i_s = 1'b1;
      end else if (d_req_valid) begin
        grant_d_s = 1'b1;
      end else begin
        grant_i_s = 1'b0;
        grant_d_s = 1'b0;
      end
    end else begin
      grant_i_s = 1'b0;
      grant_d_s = 1'b0;
    end
  end

  // Ready is the grant itself. It is gated by RESET so that both readies read
  // 0 while reset is asserted, even if a requester is already holding valid.
  assign i_req_ready = grant_i_s & RESET;
  assign d_req_ready = grant_d_s & RESET;

  // Request mux and the events that drive the FSM.
  always_comb begin
    sel_rw_s     = i_req_rw;
    sel_addr_s   = i_req_addr;
    sel_wdata_s  = i_req_wdata;
    if (grant_d_s) begin
      sel_rw_s    = d_req_rw;
      sel_addr_s  = d_req_addr;
      sel_wdata_s = d_req_wdata;
    end else begin
      sel_rw_s    = i_req_rw;
      sel_addr_s  = i_req_addr;
      sel_wdata_s = i_req_wdata;
    end
    accept_s     = grant_i_s | grant_d_s;
    issue_done_s = (state_r == ISSUE) && mem_ready;
    resp_hit_s   = (state_r == WAIT_RESP) && mem_resp_valid;
    // A response arriving in the expiry cycle wins over the watchdog.
    timeout_s    = WDOG_EN && (state_r == WAIT_RESP) && !mem_resp_valid &&
                   (cnt_r == CNT_LAST);
    // A write completion and a watchdog error both return an all-zero line.
    if (resp_hit_s && !rw_r) begin
      resp_data_s = mem_rdata;
    end else begin
      resp_data_s = '0;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (issue_done_s) begin
          state_s = WAIT_RESP;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_RESP: begin
        if (resp_hit_s || timeout_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAIT_RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      busy_r  <= (state_s != IDLE);
    end
  end

  // Captured request, arbitration history, RAM request and watchdog counter.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      owner_r     <= PORT_D;
      rr_last_r   <= PORT_I;
      rw_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      mem_valid_r <= 1'b0;
      cnt_r       <= '0;
    end else begin
      if (accept_s) begin
        owner_r     <= grant_d_s ? PORT_D : PORT_I;
        rr_last_r   <= grant_d_s ? PORT_D : PORT_I;
        rw_r        <= sel_rw_s;
        addr_r      <= sel_addr_s & LINE_MASK;
        wdata_r     <= sel_wdata_s;
        mem_valid_r <= 1'b1;
      end else if (issue_done_s) begin
        mem_valid_r <= 1'b0;
      end else begin
        mem_valid_r <= mem_valid_r;
      end
      if (issue_done_s) begin
        cnt_r <= '0;
      end else if (state_r == WAIT_RESP) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // One-cycle response pulse to the owner only. The read line is held between
  // pulses.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      i_resp_valid_r <= 1'b0;
      i_resp_err_r   <= 1'b0;
      i_resp_rdata_r <= '0;
      d_resp_valid_r <= 1'b0;
      d_resp_err_r   <= 1'b0;
      d_resp_rdata_r <= '0;
    end else begin
      i_resp_valid_r <= 1'b0;
      i_resp_err_r   <= 1'b0;
      d_resp_valid_r <= 1'b0;
      d_resp_err_r   <= 1'b0;
      if (resp_hit_s || timeout_s) begin
        if (owner_r == PORT_D) begin
          d_resp_valid_r <= 1'b1;
          d_resp_err_r   <= ~resp_hit_s;
          d_resp_rdata_r <= resp_data_s;
        end else begin
          i_resp_valid_r <= 1'b1;
          i_resp_err_r   <= ~resp_hit_s;
          i_resp_rdata_r <= resp_data_s;
        end
      end else begin
        i_resp_rdata_r <= i_resp_rdata_r;
        d_resp_rdata_r <= d_resp_rdata_r;
      end
    end
  end

  assign mem_valid    = mem_valid_r;
  assign mem_rw       = rw_r;
  assign mem_addr     = addr_r;
  assign mem_wdata    = wdata_r;
  assign busy         = busy_r;
  assign i_resp_valid = i_resp_valid_r;
  assign i_resp_err   = i_resp_err_r;
  assign i_resp_rdata = i_resp_rdata_r;
  assign d_resp_valid = d_resp_valid_r;
  assign d_resp_err   = d_resp_err_r;
  assign d_resp_rdata = d_resp_rdata_r;

endmodule

// File: tb/tb_line_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_line_mem_arbiter
//
// Self-checking bench for line_mem_arbiter, instantiated with RESP_TIMEOUT=8.
// Expected behaviour comes from a transaction-level reference model:
//   - the winner is the lone requester, or else the port that did not win last
//   - the mem address is the byte address rounded down to a 16-byte line
//   - a RAM response j cycles into the wait wins if j <= TIMEOUT-1; otherwise
//     the error response arrives TIMEOUT cycles after the wait begins
// -----------------------------------------------------------------------------
module tb_line_mem_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 128;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          RESET;
  logic          i_req_valid, i_req_rw, i_req_ready, i_resp_valid, i_resp_err;
  logic [AW-1:0] i_req_addr;
  logic [LW-1:0] i_req_wdata, i_resp_rdata;
  logic          d_req_valid, d_req_rw, d_req_ready, d_resp_valid, d_resp_err;
  logic [AW-1:0] d_req_addr;
  logic [LW-1:0] d_req_wdata, d_resp_rdata;
  logic          mem_valid, mem_rw, mem_ready, mem_resp_valid, busy;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  int n_checks = 0;
  int n_pass   = 0;
  bit last_d;

  always #5 clk = ~clk;

  line_mem_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RESP_TIMEOUT(TMO), .CNT_WIDTH(4)
  ) dut (
    .clk(clk), .RESET(RESET),
    .i_req_valid(i_req_valid), .i_req_rw(i_req_rw), .i_req_addr(i_req_addr),
    .i_req_wdata(i_req_wdata), .i_req_ready(i_req_ready),
    .i_resp_valid(i_resp_valid), .i_resp_rdata(i_resp_rdata), .i_resp_err(i_resp_err),
    .d_req_valid(d_req_valid), .d_req_rw(d_req_rw), .d_req_addr(d_req_addr),
    .d_req_wdata(d_req_wdata), .d_req_ready(d_req_ready),
    .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata), .d_resp_err(d_resp_err),
    .mem_valid(mem_valid), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [LW-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [AW-1:0] line_of(input logic [AW-1:0] a);
    return a - (a % 16);
  endfunction

  task automatic drive_req(input bit pd, input bit v, input bit rw,
                           input logic [AW-1:0] a, input logic [LW-1:0] wd);
    if (pd) begin
      d_req_valid = v; d_req_rw = rw; d_req_addr = a; d_req_wdata = wd;
    end else begin
      i_req_valid = v; i_req_rw = rw; i_req_addr = a; i_req_wdata = wd;
    end
  endtask

  // One transaction on a single port. rdy_dly: number of ISSUE cycles with
  // mem_ready low. rsp_dly: the WAIT_RESP cycle (0-based) in which RAM responds,
  // or -1 for never.
  task automatic do_txn(input bit pd, input bit rw, input logic [AW-1:0] a,
                        input logic [LW-1:0] wd, input int rdy_dly,
                        input int rsp_dly, input logic [LW-1:0] rd);
    bit            exp_err;
    int            last_j;
    logic [LW-1:0] exp_data;
    exp_err  = !(rsp_dly >= 0 && rsp_dly < TMO);
    last_j   = exp_err ? TMO - 1 : rsp_dly;
    exp_data = (exp_err || rw) ? '0 : rd;
    drive_req(pd, 1'b1, rw, a, wd);
    #1;
    check("own_ready", pd ? d_req_ready : i_req_ready, 1'b1);
    check("other_ready", pd ? i_req_ready : d_req_ready, 1'b0);
    last_d = pd;
    tick();
    drive_req(pd, 1'b0, rw, a, wd);
    for (int k = 0; k <= rdy_dly; k++) begin
      mem_ready = (k == rdy_dly);
      #1;
      check("issue_valid", mem_valid, 1'b1);
      check("issue_addr", mem_addr, line_of(a));
      check("issue_wdata", mem_wdata, wd);
      check("issue_rw", mem_rw, rw);
      check("issue_busy", busy, 1'b1);
      tick();
    end
    mem_ready = 1'b0;
    for (int j = 0; j <= last_j; j++) begin
      mem_resp_valid = (j == rsp_dly);
      mem_rdata      = (j == rsp_dly) ? rd : rnd_line();
      #1;
      check("wait_memvalid", mem_valid, 1'b0);
      check("wait_no_resp", {i_resp_valid, d_resp_valid}, 2'b00);
      tick();
    end
    mem_resp_valid = 1'b0;
    #1;
    check("resp_valid", pd ? d_resp_valid : i_resp_valid, 1'b1);
    check("resp_other", pd ? i_resp_valid : d_resp_valid, 1'b0);
    check("resp_err", pd ? d_resp_err : i_resp_err, exp_err);
    check("resp_rdata", pd ? d_resp_rdata : i_resp_rdata, exp_data);
    check("resp_busy", busy, 1'b0);
    tick();
    check("pulse_end", {i_resp_valid, d_resp_valid}, 2'b00);
    if (rsp_dly >= TMO) begin
      mem_resp_valid = 1'b1;
      mem_rdata      = rd;
      tick();
      mem_resp_valid = 1'b0;
      #1;
      check("late_ignored", {i_resp_valid, d_resp_valid, busy}, 3'b000);
      tick();
    end
  endtask

  initial begin
    bit            win_d;
    logic [LW-1:0] pat;
    RESET = 1'b0;
    i_req_valid = 1'b1; i_req_rw = 1'b0; i_req_addr = 32'h0000_0104; i_req_wdata = '0;
    d_req_valid = 1'b1; d_req_rw = 1'b0; d_req_addr = 32'h0000_0208; d_req_wdata = '0;
    mem_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    #1;
    check("rst_ready", {i_req_ready, d_req_ready}, 2'b00);
    check("rst_outs", {mem_valid, mem_rw, busy, i_resp_valid, d_resp_valid, i_resp_err, d_resp_err}, 7'd0);
    check("rst_addr", mem_addr, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    RESET = 1'b1;

    // Both ports request continuously from reset: expect D, I, D, I.
    last_d    = 1'b0;
    mem_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      win_d = !last_d;
      #1;
      check("rr_i_ready", i_req_ready, !win_d);
      check("rr_d_ready", d_req_ready, win_d);
      if (t > 0) begin
        check("rr_b2b_resp", last_d ? d_resp_valid : i_resp_valid, 1'b1);
        check("rr_b2b_data", last_d ? d_resp_rdata : i_resp_rdata, pat);
      end
      tick();
      last_d = win_d;
      #1;
      check("rr_addr", mem_addr, win_d ? 32'h0000_0200 : 32'h0000_0100);
      tick();
      pat            = {4{32'hC0DE_0000 + t}};
      mem_resp_valid = 1'b1;
      mem_rdata      = pat;
      tick();
      mem_resp_valid = 1'b0;
    end
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    mem_ready   = 1'b0;
    #1;
    check("rr_last_resp", i_resp_valid, 1'b1);
    check("rr_last_data", i_resp_rdata, pat);
    tick();

    // Single D read.
    do_txn(1'b1, 1'b0, 32'h0000_1234, rnd_line(), 0, 0, {32{4'hA}});
    // D write with mem_ready held low 5 cycles.
    do_txn(1'b1, 1'b1, 32'h0000_2000, {32{4'h1}}, 5, 2, rnd_line());
    // Watchdog expiry, then a late response in IDLE.
    do_txn(1'b0, 1'b0, 32'h0000_3008, rnd_line(), 1, 12, rnd_line());
    do_txn(1'b1, 1'b1, 32'h0000_300C, rnd_line(), 0, -1, rnd_line());
    // Response in the watchdog expiry cycle: the response wins.
    do_txn(1'b0, 1'b0, 32'h0000_5557, rnd_line(), 0, TMO - 1, {4{32'h5A5A_1234}});

    // Reset asserted during WAIT_RESP.
    drive_req(1'b1, 1'b1, 1'b0, 32'h0000_4444, {4{32'hDEAD_BEEF}});
    tick();
    drive_req(1'b1, 1'b0, 1'b0, 32'h0000_4444, '0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    #2;
    RESET = 1'b0;
    i_req_valid = 1'b1;
    d_req_valid = 1'b1;
    #1;
    check("arst_ready", {i_req_ready, d_req_ready}, 2'b00);
    check("arst_outs", {mem_valid, mem_rw, busy, i_resp_valid, d_resp_valid, i_resp_err, d_resp_err}, 7'd0);
    check("arst_addr", mem_addr, 32'd0);
    check("arst_wdata", mem_wdata, '0);
    check("arst_rdata", {i_resp_rdata, d_resp_rdata}, 256'd0);
    mem_resp_valid = 1'b1;
    mem_rdata      = rnd_line();
    tick();
    i_req_valid = 1'b0;
    d_req_valid = 1'b0;
    RESET       = 1'b1;
    tick();
    mem_resp_valid = 1'b0;
    #1;
    check("stale_ignored", {i_resp_valid, d_resp_valid, busy}, 3'b000);
    tick();
    last_d = 1'b0;
    do_txn(1'b1, 1'b0, 32'h0000_6010, rnd_line(), 0, 1, rnd_line());

    // Randomized single-port transactions.
    for (int n = 0; n < 24; n++) begin
      int r;
      r = int'($urandom_range(0, 12));
      do_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
             rnd_line(), int'($urandom_range(0, 3)), (r == 12) ? -1 : r, rnd_line());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/line_mem_arbiter.md
Name: line_mem_arbiter

Overview:
- Shares the single line-wide RAM port between the instruction-cache miss path (port I) and the data-cache writeback/allocate path (port D).
- Accepts one line transaction at a time, either a 128-bit refill read or a 128-bit writeback.
- Arbitrates I and D round-robin, issues the transaction to RAM, and routes the response back to the owning requester.
- Adds a response watchdog so a hung RAM cannot deadlock both caches.

Parameters:
ADDR_WIDTH, 32, byte address width on all ports
LINE_WIDTH, 128, cache line width in bits (4 x 32-bit words)
RESP_TIMEOUT, 1023, cycles waited in WAIT_RESP before an error response; 0 disables the watchdog
CNT_WIDTH, 10, width of the watchdog counter; must satisfy 2^CNT_WIDTH > RESP_TIMEOUT

Ports:
clk  in  1  single clock, rising edge
RESET  in  1  asynchronous, active-low reset
i_req_valid  in  1  port I request valid
i_req_rw  in  1  port I: 0=line read, 1=line write
i_req_addr  in  ADDR_WIDTH  port I byte address
i_req_wdata  in  LINE_WIDTH  port I write line
i_req_ready  out  1  port I request accepted this cycle
i_resp_valid  out  1  port I response pulse, 1 cycle
i_resp_rdata  out  LINE_WIDTH  port I read line, valid with i_resp_valid
i_resp_err  out  1  port I response is a watchdog error
d_req_valid, d_req_rw, d_req_addr, d_req_wdata, d_req_ready, d_resp_valid, d_resp_rdata, d_resp_err  same as port I, for port D
mem_valid  out  1  RAM request valid
mem_rw  out  1  RAM 0=read, 1=write
mem_addr  out  ADDR_WIDTH  RAM line address, bits [3:0] forced to 0
mem_wdata  out  LINE_WIDTH  RAM write line
mem_ready  in  1  RAM accepts request when mem_valid & mem_ready
mem_resp_valid  in  1  RAM response: read data valid or write done
mem_rdata  in  LINE_WIDTH  RAM read line
busy  out  1  high in any state other than IDLE

Behaviour:
- States: IDLE, ISSUE, WAIT_RESP.
- Reset (RESET=0, asynchronous):
  - state=IDLE; all *_ready, *_resp_valid, *_resp_err, mem_valid, mem_rw, busy = 0.
  - mem_addr, mem_wdata, *_resp_rdata = 0.
  - owner=D; rr_last=I, so D wins the first tie.
  - Watchdog counter = 0.
  - An in-flight transaction is dropped. No response is ever delivered for it, and late mem_resp_valid is ignored.
- IDLE:
  - Grant is combinational from the valids and rr_last. Only one of i_req_valid/d_req_valid high: grant that port. Both high: grant the port != rr_last.
  - Granted port's *_req_ready = 1 in the same cycle. The other ready stays 0.
  - On the handshake edge, register:
    - rw
    - addr with [3:0] cleared
    - wdata; for reads, wdata is registered as-is and ignored
  - On the same edge: owner=granted, rr_last=granted, state goes to ISSUE.
- ISSUE:
  - mem_valid=1 with the registered rw/addr/wdata, held stable until mem_ready.
  - mem_valid&mem_ready: next state WAIT_RESP, mem_valid=0 next cycle, counter cleared.
  - mem_resp_valid in ISSUE is ignored.
- WAIT_RESP:
  - Counter increments each cycle.
  - mem_resp_valid: next cycle pulse owner's resp_valid=1, resp_err=0. resp_rdata = registered mem_rdata for reads, 0 for writes. state goes to IDLE.
  - Counter == RESP_TIMEOUT-1 with no mem_resp_valid (RESP_TIMEOUT != 0): next cycle pulse owner's resp_valid=1, resp_err=1, resp_rdata=0. state goes to IDLE.
  - mem_resp_valid and timeout in the same cycle: the response wins, err=0.
- Response visibility:
  - resp_valid goes high in the cycle state is back in IDLE.
  - A new grant may be given in that same cycle, so back-to-back operation is possible.
  - The non-owner's resp_valid is never asserted.
- Requester rules:
  - Hold valid/rw/addr/wdata stable until ready.
  - Dropping valid before ready is allowed and cancels the request; it is not latched.
- Latency with RAM ready immediately and a 1-cycle response:
  - req accept at cycle 0
  - mem_valid at cycle 1
  - mem_resp_valid at cycle 2
  - resp_valid at cycle 3
- Fairness: with both ports continuously requesting, grants strictly alternate. Neither port waits more than one full transaction.
- Outputs: *_ready is combinational. Everything else is registered.

Test Plan:
- Single D read of addr 0x0000_1234, mem_ready=1, resp at next cycle with mem_rdata=0xAAAA...: mem_addr=0x0000_1230, mem_rw=0, d_resp_valid 1-cycle pulse at cycle 3 with d_resp_rdata=0xAAAA..., i_resp_valid stays 0.
- I and D both valid from reset: D granted first. I is granted in the cycle D's response returns. Then D again, alternating D,I,D,I over 4 transactions.
- D write 0x0000_2000 with wdata=0x1111..., mem_ready held low 5 cycles: mem_valid/mem_addr/mem_wdata stable all 5 cycles. d_resp_valid fires once after mem_resp_valid with rdata=0 and err=0.
- RESP_TIMEOUT=8, RAM never responds: owner's resp_valid=1 with err=1 and rdata=0 exactly 8 cycles after entering WAIT_RESP. A mem_resp_valid arriving later in IDLE causes no pulse.
- RESET low during WAIT_RESP: all outputs 0 immediately, without waiting for a clock edge. After release the next request is issued normally, and the stale mem_resp_valid produces no response.
- mem_resp_valid and watchdog expiry in the same cycle: err=0 and rdata=mem_rdata.
